// File: rtl/fsm_pkg.sv
// Shared types and 7-segment glyphs for the car-park gate controller.
package fsm_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_PASS  = 3'd1,
    WRONG_PASS = 3'd2,
    RIGHT_PASS = 3'd3,
    STOP       = 3'd4
  } state_t;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_G     = 7'b0000010;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_P     = 7'b0001100;

endpackage

// File: rtl/fsm_display.sv
// Combinational map from gate state and previous LED values to the next LED/HEX values.
module fsm_display
  import fsm_pkg::*;
(
  input  state_t     state,
  input  logic       green_prev,
  input  logic       red_prev,
  output logic       green_nxt,
  output logic       red_nxt,
  output logic [6:0] hex1_nxt,
  output logic [6:0] hex2_nxt
);

  always_comb begin
    green_nxt = 1'b0;
    red_nxt   = 1'b0;
    hex1_nxt  = SEG_BLANK;
    hex2_nxt  = SEG_BLANK;
    case (state)
      WAIT_PASS: begin
        red_nxt  = 1'b1;
        hex1_nxt = SEG_E;
        hex2_nxt = SEG_N;
      end
      WRONG_PASS: begin
        red_nxt  = ~red_prev;
        hex1_nxt = SEG_E;
        hex2_nxt = SEG_E;
      end
      RIGHT_PASS: begin
        green_nxt = ~green_prev;
        hex1_nxt  = SEG_G;
        hex2_nxt  = SEG_O;
      end
      STOP: begin
        red_nxt  = ~red_prev;
        hex1_nxt = SEG_S;
        hex2_nxt = SEG_P;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fsm.sv
// Car-park gate controller: entrance detect, fixed wait, password check, tailgate stop.
// Outputs are registered from the current state, so they trail the state by one clock.
module fsm
  import fsm_pkg::*;
#(
  parameter int         WAIT_CYCLES = 4,
  parameter logic [1:0] PASS1_VAL   = 2'b01,
  parameter logic [1:0] PASS2_VAL   = 2'b10
) (
  input  logic       clk,
  input  logic       sensor_entrance,
  input  logic       sensor_exit,
  input  logic       reset_n,
  input  logic [1:0] pass1,
  input  logic [1:0] pass2,
  output logic       green_led,
  output logic       red_led,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2
);

  localparam int               CNT_W    = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             green_q, green_d;
  logic             red_q, red_d;
  logic [6:0]       hex1_q, hex1_d;
  logic [6:0]       hex2_q, hex2_d;
  logic             pass_ok;

  assign pass_ok = (pass1 == PASS1_VAL) && (pass2 == PASS2_VAL);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (sensor_entrance) state_d = WAIT_PASS;
      end
      WAIT_PASS: begin
        if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = pass_ok ? RIGHT_PASS : WRONG_PASS;
        end
      end
      WRONG_PASS: begin
        if (pass_ok) state_d = RIGHT_PASS;
      end
      RIGHT_PASS: begin
        // Both sensors high means a second car is following the first through
        if (sensor_entrance && sensor_exit) state_d = STOP;
        else if (sensor_exit)               state_d = IDLE;
      end
      STOP: begin
        if (pass_ok) state_d = RIGHT_PASS;
      end
      default: state_d = IDLE;
    endcase
  end

  fsm_display u_display (
    .state      (state_q),
    .green_prev (green_q),
    .red_prev   (red_q),
    .green_nxt  (green_d),
    .red_nxt    (red_d),
    .hex1_nxt   (hex1_d),
    .hex2_nxt   (hex2_d)
  );

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
      hex1_q  <= SEG_BLANK;
      hex2_q  <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      green_q <= green_d;
      red_q   <= red_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
    end
  end

  assign green_led = green_q;
  assign red_led   = red_q;
  assign HEX_1     = hex1_q;
  assign HEX_2     = hex2_q;

endmodule

// File: tb/tb_fsm.sv
// Directed-vector bench for the car-park gate controller; checks {green,red,HEX_1,HEX_2} every edge.
module tb_fsm;

  localparam logic [6:0] B  = 7'h7F;
  localparam logic [6:0] E  = 7'b0000110;
  localparam logic [6:0] N  = 7'b0101011;
  localparam logic [6:0] G  = 7'b0000010;
  localparam logic [6:0] O  = 7'b1000000;
  localparam logic [6:0] S  = 7'b0010010;
  localparam logic [6:0] P  = 7'b0001100;

  logic       clk = 1'b0;
  logic       sensor_entrance;
  logic       sensor_exit;
  logic       reset_n;
  logic [1:0] pass1;
  logic [1:0] pass2;
  logic       green_led;
  logic       red_led;
  logic [6:0] HEX_1;
  logic [6:0] HEX_2;

  int n_vec = 0;
  int n_bad = 0;

  fsm dut (
    .clk             (clk),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .reset_n         (reset_n),
    .pass1           (pass1),
    .pass2           (pass2),
    .green_led       (green_led),
    .red_led         (red_led),
    .HEX_1           (HEX_1),
    .HEX_2           (HEX_2)
  );

  always #3 clk = ~clk;

  function automatic logic [15:0] vec(input logic g, input logic r,
                                      input logic [6:0] h1, input logic [6:0] h2);
    return {g, r, h1, h2};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got g=%b r=%b hex1=%b hex2=%b, want g=%b r=%b hex1=%b hex2=%b",
               tag, obs[15], obs[14], obs[13:7], obs[6:0], exp[15], exp[14], exp[13:7], exp[6:0]);
    end
  endtask

  // Advance one edge and compare outputs 1 ns later; inputs may then be changed.
  task automatic tick(input string tag, input logic [15:0] exp);
    @(posedge clk);
    #1;
    check(tag, {green_led, red_led, HEX_1, HEX_2}, exp);
  endtask

  initial begin
    reset_n = 1'b1; sensor_entrance = 1'b0; sensor_exit = 1'b0; pass1 = 2'd0; pass2 = 2'd0;
    tick("reset", vec(0, 0, B, B));

    reset_n = 1'b0; sensor_entrance = 1'b1;
    tick("idle_to_wait", vec(0, 0, B, B));
    sensor_entrance = 1'b0;
    tick("wait_0", vec(0, 1, E, N));
    tick("wait_1", vec(0, 1, E, N));
    tick("wait_2", vec(0, 1, E, N));
    tick("wait_3", vec(0, 1, E, N));
    tick("wrong_0", vec(0, 0, E, E));
    pass1 = 2'd1; pass2 = 2'd0;
    tick("wrong_p1only", vec(0, 1, E, E));
    pass1 = 2'd0; pass2 = 2'd2;
    tick("wrong_p2only", vec(0, 0, E, E));
    pass1 = 2'd1; pass2 = 2'd2;
    tick("wrong_to_right", vec(0, 1, E, E));
    tick("right_0", vec(1, 0, G, O));
    tick("right_1", vec(0, 0, G, O));
    tick("right_2", vec(1, 0, G, O));

    sensor_entrance = 1'b1; sensor_exit = 1'b1;
    tick("tailgate_right", vec(0, 0, G, O));
    tick("tailgate_stop", vec(0, 1, S, P));
    tick("alt_right", vec(1, 0, G, O));
    tick("alt_stop", vec(0, 1, S, P));
    pass1 = 2'd0; pass2 = 2'd0;
    tick("right_before_hold", vec(1, 0, G, O));
    tick("stop_hold_0", vec(0, 1, S, P));
    tick("stop_hold_1", vec(0, 0, S, P));

    pass1 = 2'd1; pass2 = 2'd2; sensor_entrance = 1'b0; sensor_exit = 1'b1;
    tick("stop_to_right", vec(0, 1, S, P));
    tick("right_to_idle", vec(1, 0, G, O));
    tick("idle_exit_ignored", vec(0, 0, B, B));
    tick("idle_stay", vec(0, 0, B, B));

    sensor_entrance = 1'b1; sensor_exit = 1'b0; pass1 = 2'd0; pass2 = 2'd0;
    tick("reentry_idle", vec(0, 0, B, B));
    tick("mid_wait_0", vec(0, 1, E, N));
    tick("mid_wait_1", vec(0, 1, E, N));
    reset_n = 1'b1;
    tick("mid_reset", vec(0, 0, B, B));
    reset_n = 1'b0; pass1 = 2'd1; pass2 = 2'd2;
    tick("post_reset_idle", vec(0, 0, B, B));
    sensor_entrance = 1'b0;
    tick("full_wait_0", vec(0, 1, E, N));
    tick("full_wait_1", vec(0, 1, E, N));
    tick("full_wait_2", vec(0, 1, E, N));
    tick("full_wait_3", vec(0, 1, E, N));
    tick("wait_to_right", vec(1, 0, G, O));
    reset_n = 1'b1;
    tick("reset_from_right", vec(0, 0, B, B));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
